// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - dual-port memory responder with optional posted-store buffer
// Optional feature macro: MEMRESP_STBUF_EN (store buffer with forwarding; default build writes the array directly).
module mem_responder #(
  parameter int MEM_WORDS   = 1024,
  parameter int STBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  input  logic [1:0]  im_command,
  output logic [31:0] instruction,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2mem_data,
  output logic [31:0] mem2proc_data,
  output logic [2:0]  stbuf_count,
  output logic        stbuf_full
);

  // Bus command encodings; the spare code 2'b11 matches neither and so behaves as idle.
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int AW = $clog2(MEM_WORDS);

  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic          d_store;
  logic [31:0]   arr_i;
  logic [31:0]   arr_d;
  logic [31:0]   i_rd;
  logic [31:0]   d_rd;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;

  logic [31:0]   mem_q [MEM_WORDS];

  // Byte addresses fold onto the array; offset and high bits are dropped so addresses wrap.
  assign i_idx   = pc_addr[AW+1:2];
  assign d_idx   = proc2Dmem_addr[AW+1:2];
  assign d_store = (proc2Dmem_command == BUS_STORE);
  assign arr_i   = mem_q[i_idx];
  assign arr_d   = mem_q[d_idx];

  logic unused_bits;
  assign unused_bits = ^{pc_addr[31:AW+2], pc_addr[1:0],
                         proc2Dmem_addr[31:AW+2], proc2Dmem_addr[1:0],
                         (STBUF_DEPTH > 0)};

  // Single array write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

`ifdef MEMRESP_STBUF_EN
  localparam int PW = (STBUF_DEPTH > 1) ? $clog2(STBUF_DEPTH) : 1;
  localparam int CW = $clog2(STBUF_DEPTH + 1);

  logic [AW-1:0]          sb_idx_q  [STBUF_DEPTH];
  logic [AW-1:0]          sb_idx_d  [STBUF_DEPTH];
  logic [31:0]            sb_data_q [STBUF_DEPTH];
  logic [31:0]            sb_data_d [STBUF_DEPTH];
  logic [STBUF_DEPTH-1:0] sb_valid_q;
  logic [STBUF_DEPTH-1:0] sb_valid_d;
  logic [PW-1:0]          head_q;
  logic [PW-1:0]          head_d;
  logic [PW-1:0]          tail_q;
  logic [PW-1:0]          tail_d;
  logic [CW-1:0]          count_q;
  logic [CW-1:0]          count_d;
  logic                   full;
  logic                   drain;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(STBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count_q == CW'(STBUF_DEPTH));
  // Retire the oldest entry whenever the data port is not storing, or to make room for a store.
  assign drain = (count_q != '0) && (!d_store || full);

  // Forwarding: walk entries oldest to youngest so the youngest match wins on each port.
  always_comb begin
    i_rd = arr_i;
    d_rd = arr_d;
    for (int k = 0; k < STBUF_DEPTH; k++) begin
      int            p;
      logic [PW-1:0] pos;
      p = int'(head_q) + k;
      if (p >= STBUF_DEPTH) p = p - STBUF_DEPTH;
      pos = PW'(p);
      if (sb_valid_q[pos] && (sb_idx_q[pos] == i_idx)) i_rd = sb_data_q[pos];
      if (sb_valid_q[pos] && (sb_idx_q[pos] == d_idx)) d_rd = sb_data_q[pos];
    end
  end

  // Next-state for the FIFO: drain at head first, then enqueue at tail (same slot when full).
  always_comb begin
    sb_idx_d   = sb_idx_q;
    sb_data_d  = sb_data_q;
    sb_valid_d = sb_valid_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (drain) begin
      sb_valid_d[head_q] = 1'b0;
      head_d             = ptr_inc(head_q);
    end
    if (d_store) begin
      sb_valid_d[tail_q] = 1'b1;
      sb_idx_d[tail_q]   = d_idx;
      sb_data_d[tail_q]  = proc2mem_data;
      tail_d             = ptr_inc(tail_q);
    end
    if (d_store && !drain) begin
      count_d = count_q + 1'b1;
    end else if (!d_store && drain) begin
      count_d = count_q - 1'b1;
    end
  end

  // Drained entry goes to the array on the same edge that removes it from the buffer.
  always_comb begin
    wr_en   = drain && !rst;
    wr_idx  = sb_idx_q[head_q];
    wr_data = sb_data_q[head_q];
  end

  // Buffer control state; reset discards every pending store.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid_q <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      sb_valid_q <= sb_valid_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Buffer payload needs no reset; it is only observed through valid bits.
  always_ff @(posedge clk) begin
    sb_idx_q  <= sb_idx_d;
    sb_data_q <= sb_data_d;
  end

  assign stbuf_count = 3'(count_q);
  assign stbuf_full  = full;
`else
  // No buffer: stores land in the array at the end of their cycle, reads see the array only.
  always_comb begin
    i_rd    = arr_i;
    d_rd    = arr_d;
    wr_en   = d_store && !rst;
    wr_idx  = d_idx;
    wr_data = proc2mem_data;
  end

  assign stbuf_count = 3'd0;
  assign stbuf_full  = 1'b0;
`endif

  // Zero-latency read outputs, forced to zero unless the port is loading.
  always_comb begin
    instruction   = (im_command == BUS_LOAD) ? i_rd : 32'h0;
    mem2proc_data = (proc2Dmem_command == BUS_LOAD) ? d_rd : 32'h0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder against a queue-based model
module tb_mem_responder;

  localparam int MW = 1024;
  localparam int SD = 4;
  localparam logic [1:0] NONE  = 2'h0;
  localparam logic [1:0] LOAD  = 2'h1;
  localparam logic [1:0] STORE = 2'h2;
`ifdef MEMRESP_STBUF_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_addr = '0;
  logic [1:0]  im_command = NONE;
  logic [31:0] instruction;
  logic [31:0] proc2Dmem_addr = '0;
  logic [1:0]  proc2Dmem_command = NONE;
  logic [31:0] proc2mem_data = '0;
  logic [31:0] mem2proc_data;
  logic [2:0]  stbuf_count;
  logic        stbuf_full;

  int n_vec = 0;
  int n_err = 0;

  mem_responder #(.MEM_WORDS(MW), .STBUF_DEPTH(SD)) dut (
    .clk(clk), .rst(rst),
    .pc_addr(pc_addr), .im_command(im_command), .instruction(instruction),
    .proc2Dmem_addr(proc2Dmem_addr), .proc2Dmem_command(proc2Dmem_command),
    .proc2mem_data(proc2mem_data), .mem2proc_data(mem2proc_data),
    .stbuf_count(stbuf_count), .stbuf_full(stbuf_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the memory the processor sees is the array overlaid by pending stores, newest last.
  typedef struct { int idx; logic [31:0] data; } ent_t;
  ent_t        pend[$];
  logic [31:0] arr   [MW];
  bit          known [MW];

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % MW);
  endfunction

  function automatic bit model_rd(input logic [31:0] a, output logic [31:0] v);
    int ix;
    ix = widx(a);
    for (int i = pend.size() - 1; i >= 0; i--) begin
      if (pend[i].idx == ix) begin
        v = pend[i].data;
        return 1'b1;
      end
    end
    v = arr[ix];
    return known[ix];
  endfunction

  task automatic retire();
    ent_t e;
    e = pend.pop_front();
    arr[e.idx]   = e.data;
    known[e.idx] = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
    end else if (proc2Dmem_command == STORE) begin
      if (EN) begin
        if (pend.size() == SD) retire();
        pend.push_back('{widx(proc2Dmem_addr), proc2mem_data});
      end else begin
        arr[widx(proc2Dmem_addr)]   = proc2mem_data;
        known[widx(proc2Dmem_addr)] = 1'b1;
      end
    end else if (pend.size() > 0) begin
      retire();
    end
  end

  always @(negedge clk) begin : cmp
    logic [31:0] v;
    if (im_command == LOAD) begin
      if (model_rd(pc_addr, v)) chk("model_instr", instruction, v);
    end else begin
      chk("model_instr_idle", instruction, 32'h0);
    end
    if (proc2Dmem_command == LOAD) begin
      if (model_rd(proc2Dmem_addr, v)) chk("model_ldata", mem2proc_data, v);
    end else begin
      chk("model_ldata_idle", mem2proc_data, 32'h0);
    end
    chk("model_count", {29'h0, stbuf_count}, 32'(pend.size()));
    chk("model_full", {31'h0, stbuf_full}, {31'h0, (pend.size() == SD)});
  end

  task automatic drive(input logic [1:0] ic, input logic [31:0] pa, input logic [1:0] dc,
                       input logic [31:0] da, input logic [31:0] dd);
    im_command        = ic;
    pc_addr           = pa;
    proc2Dmem_command = dc;
    proc2Dmem_addr    = da;
    proc2mem_data     = dd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", {29'h0, stbuf_count}, 32'h0);
    chk("reset_full", {31'h0, stbuf_full}, 32'h0);
    rst = 1'b0;

    // Give words 0..39 known contents, then let the buffer empty.
    for (int i = 0; i < 40; i++) begin
      drive(NONE, 0, STORE, 32'(i * 4), 32'h1000_0000 + 32'(i));
      tick();
    end
    drive(NONE, 0, NONE, 0, 0);
    repeat (SD + 1) tick();

    // Store visible next cycle, not in its own cycle.
    drive(LOAD, 32'h40, STORE, 32'h40, 32'hDEADBEEF);
    mid();
    chk("same_cycle_old", instruction, 32'h1000_0010);
    tick();
    drive(NONE, 0, LOAD, 32'h40, 0);
    mid();
    chk("next_cycle_new", mem2proc_data, 32'hDEADBEEF);
    tick();
    drive(NONE, 0, NONE, 0, 0);
    repeat (SD) tick();

    // Fill past depth, then drain with loads in flight.
    for (int k = 1; k <= 5; k++) begin
      drive(NONE, 0, STORE, 32'((k - 1) * 4), 32'(k));
      tick();
      chk("fill_count", {29'h0, stbuf_count}, EN ? 32'((k > SD) ? SD : k) : 32'h0);
    end
    chk("fill_full", {31'h0, stbuf_full}, {31'h0, EN});
    for (int j = 0; j < 4; j++) begin
      drive(NONE, 0, LOAD, 32'(j * 4), 0);
      mid();
      chk("drain_load", mem2proc_data, 32'(j + 1));
      tick();
      chk("drain_count", {29'h0, stbuf_count}, EN ? 32'(3 - j) : 32'h0);
    end
    for (int j = 0; j < 5; j++) begin
      drive(LOAD, 32'(j * 4), LOAD, 32'(j * 4), 0);
      mid();
      chk("after_drain_d", mem2proc_data, 32'(j + 1));
      chk("after_drain_i", instruction, 32'(j + 1));
      tick();
    end

    // Two stores to one word; youngest wins, and the array ends with it.
    drive(NONE, 0, STORE, 32'h20, 32'hA);
    tick();
    drive(NONE, 0, STORE, 32'h20, 32'hB);
    tick();
    drive(LOAD, 32'h20, NONE, 0, 0);
    mid();
    chk("youngest_fwd", instruction, 32'hB);
    tick();
    drive(NONE, 0, NONE, 0, 0);
    repeat (SD) tick();
    drive(LOAD, 32'h20, LOAD, 32'h20, 0);
    mid();
    chk("drained_word8_i", instruction, 32'hB);
    chk("drained_word8_d", mem2proc_data, 32'hB);
    tick();

    // Repeated stores to one word through a full buffer, read on the fetch port.
    for (int k = 0; k < 6; k++) begin
      drive(LOAD, 32'h8, STORE, 32'h8, 32'h100 + 32'(k));
      tick();
    end
    drive(LOAD, 32'h8, NONE, 0, 0);
    mid();
    chk("dup_youngest", instruction, 32'h105);
    tick();
    drive(NONE, 0, NONE, 0, 0);
    repeat (SD) tick();

    // Asynchronous reset mid-cycle discards pending stores.
    for (int k = 0; k < 3; k++) begin
      drive(NONE, 0, STORE, 32'h80 + 32'(k * 4), 32'hC0DE_0000 + 32'(k));
      tick();
    end
    drive(LOAD, 32'h84, LOAD, 32'h80, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_count", {29'h0, stbuf_count}, 32'h0);
    chk("async_rst_full", {31'h0, stbuf_full}, 32'h0);
    chk("rst_load_d", mem2proc_data, EN ? 32'h1000_0020 : 32'hC0DE_0000);
    chk("rst_load_i", instruction, EN ? 32'h1000_0021 : 32'hC0DE_0001);
    tick();
    rst = 1'b0;
    drive(LOAD, 32'h88, LOAD, 32'h88, 0);
    mid();
    chk("post_rst_load", mem2proc_data, EN ? 32'h1000_0022 : 32'hC0DE_0002);
    tick();

    // Spare command code is idle: no load data, no enqueue, drain continues.
    drive(NONE, 0, STORE, 32'h44, 32'h77);
    tick();
    drive(NONE, 0, 2'b11, 32'h40, 32'h99);
    mid();
    chk("cmd11_ldata", mem2proc_data, 32'h0);
    chk("cmd11_instr", instruction, 32'h0);
    chk("cmd11_count_before", {29'h0, stbuf_count}, EN ? 32'h1 : 32'h0);
    tick();
    chk("cmd11_count_after", {29'h0, stbuf_count}, 32'h0);
    drive(LOAD, 32'h44, LOAD, 32'h40, 0);
    mid();
    chk("cmd11_no_write", mem2proc_data, 32'hDEADBEEF);
    chk("cmd11_drained", instruction, 32'h77);
    tick();

    // Out-of-range address aliases onto word 0.
    drive(NONE, 0, STORE, 32'h1003, 32'h55AA55AA);
    tick();
    drive(LOAD, 32'h0, LOAD, 32'h3, 0);
    mid();
    chk("alias_d", mem2proc_data, 32'h55AA55AA);
    chk("alias_i", instruction, 32'h55AA55AA);
    tick();
    drive(NONE, 0, NONE, 0, 0);
    repeat (SD + 1) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL provide parameter MEM_WORDS, default 1024, giving the word capacity of the storage array; it SHALL be a power of two.
REQ-002 The module SHALL provide parameter STBUF_DEPTH, default 4, giving the posted-store buffer depth.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 pc_addr  input  32  instruction fetch byte address.
REQ-006 im_command  input  2  instruction port command.
REQ-007 instruction  output  32  fetched instruction word.
REQ-008 proc2Dmem_addr  input  32  data port byte address.
REQ-009 proc2Dmem_command  input  2  data port command.
REQ-010 proc2mem_data  input  32  store data.
REQ-011 mem2proc_data  output  32  load data.
REQ-012 stbuf_count  output  3  number of occupied store-buffer entries.
REQ-013 stbuf_full  output  1  high when stbuf_count equals STBUF_DEPTH.

Function
REQ-014 Commands SHALL use the sys_defs.vh encodings `BUS_NONE, `BUS_LOAD and `BUS_STORE; the unused code 2'b11 SHALL be treated as `BUS_NONE.
REQ-015 Word index SHALL be addr[log2(MEM_WORDS)+1:2]; addr[1:0] and all higher bits SHALL be ignored, so out-of-range addresses wrap.
REQ-016 Loads on either port SHALL be combinational, zero-latency: result valid in the same cycle as the command.
REQ-017 When a port's command is not `BUS_LOAD, its data output SHALL be 32'h0.
REQ-018 A store SHALL be accepted every cycle it is presented; the data port never stalls and a store is never dropped.
REQ-019 Read data SHALL come from the youngest valid buffer entry whose word index matches, or from the array when no entry matches; this applies to both ports.
REQ-020 A store presented in cycle N SHALL be visible to loads on either port from cycle N+1, never in cycle N.
REQ-021 The buffer SHALL be FIFO; on any cycle whose data command is not `BUS_STORE and the buffer is non-empty, the oldest entry SHALL be written to the array and removed at the clock edge.
REQ-022 Store with buffer not full SHALL enqueue only; count increments.
REQ-023 Store with buffer full SHALL drain the oldest entry to the array and enqueue the new store in the same edge; count stays at STBUF_DEPTH.
REQ-024 Stores to an index already buffered SHALL take a new entry; entries SHALL NOT be merged.
REQ-025 A drained entry SHALL remain visible to forwarding until the edge that writes it, with no cycle in which its value is unobservable.
REQ-026 The array SHALL have one write port, used only by drain (or by direct writes per REQ-031).

Reset
REQ-027 Asserting rst SHALL immediately clear all buffer valid bits and pointers; stbuf_count=0, stbuf_full=0.
REQ-028 Pending buffered stores at reset SHALL be discarded and never written to the array.
REQ-029 The array contents SHALL NOT be reset.
REQ-030 During reset, instruction and mem2proc_data SHALL still follow REQ-016/017 from array contents.

Configuration
REQ-031 With MEMRESP_STBUF_EN undefined, there SHALL be no buffer: a store writes the array at the edge ending its cycle, stbuf_count and stbuf_full SHALL be tied 0, and REQ-020 still holds.
REQ-032 With MEMRESP_STBUF_EN defined, REQ-019 to REQ-026 SHALL apply.

Verification
REQ-033 Store 0xDEADBEEF to 0x40 in cycle N, data load of 0x40 in cycle N+1 -> mem2proc_data=0xDEADBEEF; a load of 0x40 in cycle N instead -> the prior array value.
REQ-034 Five consecutive stores to 0x0,0x4,0x8,0xC,0x10 with values 1..5 (STBUF_DEPTH=4) -> count goes 1,2,3,4,4; then 4 idle cycles -> count 3,2,1,0; loads of 0x0-0x10 return 1..5.
REQ-035 Stores 0xA then 0xB to 0x20, then fetch at 0x20 with im_command=`BUS_LOAD -> instruction=0xB; after the buffer drains, the array at index 8 holds 0xB.
REQ-036 Three stores, then rst pulsed mid-cycle asynchronously -> count=0 immediately; loads of those addresses return pre-store array values.
REQ-037 proc2Dmem_command=2'b11 with proc2Dmem_addr=0x40, and im_command=`BUS_NONE -> both outputs 0, no enqueue, drain proceeds.
REQ-038 Store to 0x1003 and load from 0x0003 with MEM_WORDS=1024 -> index 0 is aliased and the stored value is returned.
